// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor.
// One operand slice per stage; the carry ripples one stage per cycle.
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic stall;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // operand bits still to be added on entry / after this stage
        localparam int IW = WIDTH - k * SW;
        localparam int OW = IW - SW;

        logic [IW-1:0]         ia;
        logic [IW-1:0]         ib;
        logic                  ic;
        logic                  iv;
        logic                  iam;
        logic                  ibm;
        logic [SW:0]           slc;
        logic [(k+1)*SW-1:0]   ns;
        logic [(k+1)*SW-1:0]   rs;
        logic                  rc;
        logic                  rv;
        logic                  ram;
        logic                  rbm;

        if (k == 0) begin : src
            assign ia  = a;
            assign ib  = op ? ~b : b;
            assign ic  = op | cin;
            assign iv  = in_valid;
            assign iam = a[WIDTH-1];
            assign ibm = ib[IW-1];
            assign ns  = slc[SW-1:0];
        end else begin : src
            assign ia  = stg[k-1].rem.ra;
            assign ib  = stg[k-1].rem.rb;
            assign ic  = stg[k-1].rc;
            assign iv  = stg[k-1].rv;
            assign iam = stg[k-1].ram;
            assign ibm = stg[k-1].rbm;
            assign ns  = {slc[SW-1:0], stg[k-1].rs};
        end

        assign slc = {1'b0, ia[SW-1:0]}
                   + {1'b0, ib[SW-1:0]}
                   + {{SW{1'b0}}, ic};

        // Slice result, carry and operand MSBs advance unless stalled
        always_ff @(posedge clk) begin
            if (rst) begin
                rv  <= 1'b0;
                rs  <= '0;
                rc  <= 1'b0;
                ram <= 1'b0;
                rbm <= 1'b0;
            end else if (!stall) begin
                rv <= iv;
                if (iv) begin
                    rs  <= ns;
                    rc  <= slc[SW];
                    ram <= iam;
                    rbm <= ibm;
                end
            end
        end

        if (OW > 0) begin : rem
            logic [OW-1:0] ra;
            logic [OW-1:0] rb;

            // Untouched upper operand slices travel with the partial sum
            always_ff @(posedge clk) begin
                if (rst) begin
                    ra <= '0;
                    rb <= '0;
                end else if (!stall && iv) begin
                    ra <= ia[IW-1:SW];
                    rb <= ib[IW-1:SW];
                end
            end
        end
    end

    assign stall     = stg[L].rv && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = stg[L].rv;
    assign sum       = stg[L].rs;
    assign cout      = stg[L].rc;
    assign ovf       = (stg[L].ram == stg[L].rbm)
                    && (stg[L].rs[WIDTH-1] != stg[L].ram);

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe.
// Directed vectors on a 16/2 instance plus random runs on three configs.
module tb_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic        rst;
    logic        rrst;
    logic        iv0, ir0, ov0, or0, c0, op0, co0, vf0;
    logic [15:0] a0, b0, s0;
    logic [17:0] q0[$];

    add_pipe #(.WIDTH(16), .STAGES(2)) d0 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .cin(c0), .op(op0),
        .out_valid(ov0), .out_ready(or0),
        .sum(s0), .cout(co0), .ovf(vf0)
    );

    // directed monitor
    always @(negedge clk) begin
        #2;
        if (!rst && ov0 && or0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d0_extra: got %0h expected none",
                         {vf0, co0, s0});
            end else begin
                chk("d0_result", {vf0, co0, s0}, q0.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic o,
                        input logic [17:0] e);
        int n = 0;
        a0 = x; b0 = y; c0 = c; op0 = o; iv0 = 1'b1;
        #1;
        while (!ir0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ir0) begin
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            q0.push_back(e);
        end
        @(negedge clk);
        iv0 = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("d0_drain", q0.size(), 0);
    endtask

    for (genvar i = 0; i < 3; i++) begin : g
        localparam int W = (i == 0) ? 16 : (i == 1) ? 8 : 32;
        localparam int S = (i == 0) ? 2 : (i == 1) ? 1 : 4;

        logic         iv, ir, ov, orr, c, o, co, vf, done;
        logic [W-1:0] x, y, s;
        logic [W+1:0] sbq[$];

        add_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .rst(rrst),
            .in_valid(iv), .in_ready(ir),
            .a(x), .b(y), .cin(c), .op(o),
            .out_valid(ov), .out_ready(orr),
            .sum(s), .cout(co), .ovf(vf)
        );

        function automatic logic [W+1:0] model(input logic [W-1:0] p,
                                               input logic [W-1:0] m,
                                               input logic ci,
                                               input logic sb);
            logic [W:0] r;
            logic       v;
            if (sb) begin
                r[W-1:0] = p - m;
                r[W]     = (p >= m);
                v = (p[W-1] != m[W-1]) && (r[W-1] != p[W-1]);
            end else begin
                r = {1'b0, p} + {1'b0, m} + {{W{1'b0}}, ci};
                v = (p[W-1] == m[W-1]) && (r[W-1] != p[W-1]);
            end
            return {v, r};
        endfunction

        initial begin
            orr = 1'b0;
            forever begin
                @(negedge clk);
                orr = $urandom_range(0, 2) != 0;
            end
        end

        initial begin
            int n;
            int t;
            done = 1'b0; iv = 1'b0;
            x = '0; y = '0; c = 1'b0; o = 1'b0;
            @(negedge clk);
            while (rrst) @(negedge clk);
            n = 0;
            while (n < 500) begin
                x  = W'($urandom);
                y  = W'($urandom);
                c  = 1'($urandom);
                o  = 1'($urandom);
                iv = $urandom_range(0, 3) != 0;
                #1;
                if (iv && ir) begin
                    sbq.push_back(model(x, y, c, o));
                    n++;
                end
                @(negedge clk);
            end
            iv = 1'b0;
            t = 0;
            while (sbq.size() > 0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("rand_drain_w%0d", W), sbq.size(), 0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            #2;
            if (!rrst && ov && orr) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_extra_w%0d: got %0h expected none",
                             W, {vf, co, s});
                end else begin
                    chk($sformatf("rand_w%0d", W), {vf, co, s},
                        sbq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [17:0] snap;
        int          n;
        rst = 1'b1; rrst = 1'b1;
        iv0 = 1'b0; or0 = 1'b1;
        a0 = '0; b0 = '0; c0 = 1'b0; op0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; rrst = 1'b0;
        #1;
        chk("reset_out_valid", ov0, 0);
        chk("reset_sum", s0, 0);
        chk("reset_cout", co0, 0);
        chk("reset_ovf", vf0, 0);
        chk("reset_in_ready", ir0, 1);
        @(negedge clk);

        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        chk("lat_cycle1", ov0, 0);
        @(negedge clk);
        chk("lat_cycle2", ov0, 1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
        send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h0007, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002});
        send(16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100});
        send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
        drain0();

        send(16'd1, 16'd1, 1'b0, 1'b0, 18'd2);
        send(16'd2, 16'd2, 1'b0, 1'b0, 18'd4);
        chk("bp_valid", ov0, 1);
        or0 = 1'b0;
        #1;
        snap = {vf0, co0, s0};
        chk("bp_first", snap, 18'd2);
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", ir0, 0);
            chk("bp_hold", {vf0, co0, s0}, snap);
            chk("bp_hold_valid", ov0, 1);
            @(negedge clk);
            #1;
        end
        or0 = 1'b1;
        #1;
        chk("bp_release_ready", ir0, 1);
        send(16'd3, 16'd3, 1'b0, 1'b0, 18'd6);
        send(16'd4, 16'd4, 1'b0, 1'b0, 18'd8);
        drain0();

        or0 = 1'b0;
        send(16'h1111, 16'h1111, 1'b0, 1'b0, 18'h02222);
        send(16'h2222, 16'h2222, 1'b0, 1'b0, 18'h04444);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", ov0, 0);
        chk("rst_sum", s0, 0);
        or0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_stale", ov0, 0);
        end
        send(16'h0010, 16'h0020, 1'b0, 1'b0, 18'h00030);
        chk("rst_lat1", ov0, 0);
        @(negedge clk);
        chk("rst_lat2", ov0, 1);
        drain0();

        n = 0;
        while (!(g[0].done && g[1].done && g[2].done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("rand_done", {g[0].done, g[1].done, g[2].done}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the single-bit combinational adder.
- Operands are split into STAGES equal slices. Each slice is added in its own register stage, and the carry ripples forward stage by stage.
- Uses a valid/ready handshake on input and output, with full backpressure.
- Sits in the arithmetic benchmark set as a reusable datapath element. It is checked against a behavioural golden model in post-route simulation.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥1.
- STAGES, 2, number of pipeline stages/slices; 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0; slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (add only)
- op  in  1  0 = add (a+b+cin), 1 = subtract (a−b, cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out; for subtract, 1 = no borrow (a ≥ b unsigned)
- ovf  out  1  signed overflow

Behaviour:
- Reset (rst=1 at a rising edge): all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards all in-flight data. No result from before reset ever appears.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. The whole pipeline holds while stalled. in_ready = !stall (a combinational path from out_ready is allowed).
- Subtract: b is replaced by ~b and the carry into slice 0 is forced to 1. In add mode the carry into slice 0 is cin.
- Stage k (k = 0..STAGES−1) on advance:
  - Computes slice k = a_slice_k + b_slice_k + carry_k. It is SW bits wide, plus a carry-out.
  - Registers the completed low slices 0..k, the carry-out, and the untouched upper slices of a and b.
  - Also registers the slice-MSB inputs needed for overflow.
- Latency: a result is valid exactly STAGES cycles after its input transfer when there is no stall. Each stall cycle adds one cycle.
- Throughput: one op per cycle when out_ready=1.
- Final outputs:
  - cout = carry out of the top slice.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the post-inversion operand.
- sum, cout and ovf hold stable while out_valid && !out_ready.
- Bubbles: an empty stage may be filled even when the stage ahead is empty. When not stalled, bubbles advance naturally. Data order is always preserved.
- Wrap-around: the result is modulo 2^WIDTH. For example, 0xFFFF+1 gives 0x0000 with cout=1.
- STAGES=1 degenerates to a single registered adder with latency 1.
- No combinational path from a, b, cin or op to any output.

Test Plan:
- Carry chain: WIDTH=16, STAGES=2, a=0xFFFF, b=0x0001, cin=0, op=0 → 2 cycles later sum=0x0000, cout=1, ovf=0. This checks carry crossing the slice boundary.
- Signed overflow: a=0x7FFF, b=0x0001, op=0 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, op=1 → sum=0xFFFE, cout=0, ovf=0. Also a=0x0007, b=0x0005 → sum=0x0002, cout=1.
- Backpressure: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) while holding out_ready=0 for 3 cycles mid-stream.
  - Expect results 2, 4, 6, 8 in order, with no loss or duplication.
  - in_ready=0 exactly while stalled; outputs stable during the stall.
- Reset mid-flight: launch 2 ops, assert rst for 1 cycle before either completes → out_valid=0 afterwards with no stale result. A new op 0x0010+0x0020 then returns 0x0030 after 2 cycles.
- Random regression: 500 random {a, b, cin, op} with random out_ready, compared against a golden (a±b) model over WIDTH+1 bits, run for (WIDTH, STAGES) = (16,2), (8,1) and (32,4). Zero mismatches are required.
